// File: rtl/led_pkg.sv
// Shared constants for the LED PWM peripheral: register offsets and BLINK_HALF width.
// No logic; pure compile-time definitions.
// Imported by the top module and the timebase.
package led_pkg;
  localparam logic [4:0] OFF_CTRL_WR = 5'h00;
  localparam logic [4:0] OFF_CTRL_RD = 5'h04;
  localparam logic [4:0] OFF_DUTY    = 5'h08;
  localparam logic [4:0] OFF_MASK    = 5'h0C;
  localparam logic [4:0] OFF_HALF    = 5'h10;
  localparam int         BLINK_HALF_W = 16;
endpackage

// File: rtl/led_pwm_timebase.sv
// Free-running prescaler and PWM counter; tick and frame_end are single-cycle strobes.
// Latency: strobes are combinational from the counter state; counters advance every clk.
// No backpressure: the counters are cleared only by reset.
module led_pwm_timebase
  import led_pkg::*;
#(
  parameter int PRESCALE = 16,
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  output logic [PWM_BITS-1:0] pwm_cnt,
  output logic                tick,
  output logic                frame_end
);
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] presc;

  assign tick      = (presc == PRESC_LAST);
  assign frame_end = tick & (&pwm_cnt);

  // Prescaler wraps at PRESCALE-1; PWM counter steps on each tick and wraps naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc   <= '0;
      pwm_cnt <= '0;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      if (tick) pwm_cnt <= pwm_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/led_pwm_peripheral.sv
// LED PWM peripheral: register file, bus decode, PWM compare and optional blink (macro LED_PWM_BLINK_EN).
// Latency: read data combinational; leds_o registered one cycle after any input change.
// No backpressure: bus accesses complete in the cycle they are strobed.
module led_pwm_peripheral
  import led_pkg::*;
#(
  parameter int NUM_LEDS = 8,
  parameter int PWM_BITS = 8,
  parameter int PRESCALE = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rd_en_i,
  input  logic                wr_en_i,
  input  logic [31:0]         addr_i,
  input  logic [31:0]         data_i,
  output logic [31:0]         data_o,
  output logic [NUM_LEDS-1:0] leds_o
);
  logic [4:0]          off;
  logic [NUM_LEDS-1:0] ctrl;
  logic [PWM_BITS-1:0] duty;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic                tick;
  logic                frame_end;
  logic                pwm_on;
  logic [NUM_LEDS-1:0] blink_gate;
  logic                unused_bits;

  assign off         = addr_i[4:0];
  assign unused_bits = ^{addr_i[31:5], data_i, tick, frame_end};

  led_pwm_timebase #(
    .PRESCALE (PRESCALE),
    .PWM_BITS (PWM_BITS)
  ) u_timebase (
    .clk       (clk),
    .rst       (rst),
    .pwm_cnt   (pwm_cnt),
    .tick      (tick),
    .frame_end (frame_end)
  );

  // Core registers; reset wins over a same-cycle write.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl <= '0;
      duty <= '1;
    end else if (wr_en_i) begin
      if (off == OFF_CTRL_WR) ctrl <= data_i[NUM_LEDS-1:0];
      if (off == OFF_DUTY)    duty <= data_i[PWM_BITS-1:0];
    end
  end

`ifdef LED_PWM_BLINK_EN
  logic [NUM_LEDS-1:0]     blink_mask;
  logic [BLINK_HALF_W-1:0] blink_half;
  logic [BLINK_HALF_W-1:0] blink_cnt;
  logic                    phase;

  // Blink registers and half-period counter; a BLINK_HALF write restarts the blink at phase 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      blink_mask <= '0;
      blink_half <= '0;
      blink_cnt  <= '0;
      phase      <= 1'b1;
    end else begin
      if (wr_en_i && off == OFF_MASK) blink_mask <= data_i[NUM_LEDS-1:0];
      if (wr_en_i && off == OFF_HALF) begin
        blink_half <= data_i[BLINK_HALF_W-1:0];
        blink_cnt  <= '0;
        phase      <= 1'b1;
      end else if (blink_half == '0) begin
        blink_cnt <= '0;
        phase     <= 1'b1;
      end else if (frame_end) begin
        if (blink_cnt == blink_half - 1'b1) begin
          blink_cnt <= '0;
          phase     <= ~phase;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end
    end
  end

  assign blink_gate = ~blink_mask | {NUM_LEDS{phase}};
`else
  assign blink_gate = '1;
`endif

  // Duty extremes are absolute so DUTY=all-ones is fully on rather than missing one step.
  always_comb begin
    if (duty == '0)      pwm_on = 1'b0;
    else if (&duty)      pwm_on = 1'b1;
    else                 pwm_on = (pwm_cnt < duty);
  end

  // Read mux: zero when not strobed, for write-only CTRL, and for undecoded offsets.
  always_comb begin
    data_o = '0;
    if (rd_en_i) begin
      case (off)
        OFF_CTRL_RD: data_o = 32'(ctrl);
        OFF_DUTY:    data_o = 32'(duty);
`ifdef LED_PWM_BLINK_EN
        OFF_MASK:    data_o = 32'(blink_mask);
        OFF_HALF:    data_o = 32'(blink_half);
`endif
        default:     data_o = '0;
      endcase
    end
  end

  // Registered LED drive.
  always_ff @(posedge clk) begin
    if (rst) leds_o <= '0;
    else     leds_o <= ctrl & {NUM_LEDS{pwm_on}} & blink_gate;
  end
endmodule

// File: tb/tb_led_pwm_peripheral.sv
// Self-checking bench for led_pwm_peripheral (NUM_LEDS=8, PWM_BITS=8, PRESCALE=4).
// Reference model derives PWM position and blink phase arithmetically from elapsed cycles/frames.
// Blink expectations follow LED_PWM_BLINK_EN when the macro is defined for the build.
module tb_led_pwm_peripheral;
  localparam int NL = 8;
  localparam int PS = 4;
  localparam int FRAME = PS * 256;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_en_i, wr_en_i;
  logic [31:0] addr_i, data_i, data_o;
  logic [NL-1:0] leds_o;

  int compared = 0;
  int mismatched = 0;

  // Reference state
  int          n;       // clk edges since reset released
  int          frames;  // frame ends since blink counter last cleared
  logic [7:0]  m_ctrl, m_duty, m_mask;
  int          m_half;

  led_pwm_peripheral #(.NUM_LEDS(NL), .PWM_BITS(8), .PRESCALE(PS)) dut (
    .clk(clk), .rst(rst), .rd_en_i(rd_en_i), .wr_en_i(wr_en_i),
    .addr_i(addr_i), .data_i(data_i), .data_o(data_o), .leds_o(leds_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic rd, input logic [31:0] a);
    if (!rd) return 32'h0;
    case (a[4:0])
      5'h04: return {24'h0, m_ctrl};
      5'h08: return {24'h0, m_duty};
`ifdef LED_PWM_BLINK_EN
      5'h0C: return {24'h0, m_mask};
      5'h10: return m_half;
`endif
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [NL-1:0] model_leds();
    int  pos;
    bit  on;
    bit  ph;
    pos = (n / PS) % 256;
    if (m_duty == 8'h00)      on = 1'b0;
    else if (m_duty == 8'hFF) on = 1'b1;
    else                      on = (pos < m_duty);
    ph = (m_half == 0) ? 1'b1 : (((frames / m_half) % 2) == 0);
    if (!on) return '0;
    return m_ctrl & (~m_mask | {NL{ph}});
  endfunction

  // One bus cycle: check read data before the edge, advance the model, check leds after.
  task automatic cyc(input logic r, input logic rd, input logic wr,
                     input logic [31:0] a, input logic [31:0] d);
    logic [NL-1:0] e;
    bit frame_now;
    rst = r; rd_en_i = rd; wr_en_i = wr; addr_i = a; data_i = d;
    #1;
    if (!r) chk("rdata", data_o, model_read(rd, a));
    @(posedge clk);
    if (r) begin
      e = '0;
      n = 0; frames = 0;
      m_ctrl = 8'h00; m_duty = 8'hFF; m_mask = 8'h00; m_half = 0;
    end else begin
      e = model_leds();
      frame_now = ((n % FRAME) == FRAME - 1);
      if (wr && a[4:0] == 5'h00) m_ctrl = d[7:0];
      if (wr && a[4:0] == 5'h08) m_duty = d[7:0];
`ifdef LED_PWM_BLINK_EN
      if (wr && a[4:0] == 5'h0C) m_mask = d[7:0];
      if (wr && a[4:0] == 5'h10) begin
        m_half = int'(d[15:0]);
        frames = 0;
      end else
`endif
      if (m_half == 0) frames = 0;
      else if (frame_now) frames++;
      n++;
    end
    @(negedge clk);
    chk("leds", {24'h0, leds_o}, {24'h0, e});
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    int highs;
    int toggles;
    logic [NL-1:0] prev;
    rst = 1'b1; rd_en_i = 1'b0; wr_en_i = 1'b0; addr_i = '0; data_i = '0;

    // Reset state
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 32'h04, 32'h0);
    chk("rst_ctrl", data_o, 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 32'h08, 32'h0);
    chk("rst_duty", data_o, 32'hFF);
    cyc(1'b0, 1'b1, 1'b0, 32'h00, 32'h0);
    chk("ctrl_wo_reads_0", data_o, 32'h0);

    // CTRL write, legacy read-back
    cyc(1'b0, 1'b0, 1'b1, 32'h00, 32'hFFFF_FFA5);
    idle(20);
    chk("leds_a5", {24'h0, leds_o}, 32'hA5);
    cyc(1'b0, 1'b1, 1'b0, 32'h04, 32'h0);
    chk("ctrl_rd", data_o, 32'hA5);

    // Read-during-write shows the old value
    rd_en_i = 1'b1; wr_en_i = 1'b1; addr_i = 32'h08; data_i = 32'h40; #1;
    chk("rdw_old", data_o, 32'hFF);
    cyc(1'b0, 1'b1, 1'b1, 32'h08, 32'h40);
    cyc(1'b0, 1'b1, 1'b0, 32'h08, 32'h0);
    chk("rdw_new", data_o, 32'h40);

    // 25% duty: exactly 256 high cycles in any 1024-cycle window
    cyc(1'b0, 1'b0, 1'b1, 32'h00, 32'hFF);
    idle(50);
    highs = 0;
    for (int i = 0; i < FRAME; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      if (leds_o == 8'hFF) highs++;
    end
    chk("duty40_high_cycles", highs, 256);

    // Duty extremes
    cyc(1'b0, 1'b0, 1'b1, 32'h08, 32'h00);
    highs = 0;
    for (int i = 0; i < 1100; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      if (i > 0 && leds_o != 8'h00) highs++;
    end
    chk("duty0_never_on", highs, 0);
    cyc(1'b0, 1'b0, 1'b1, 32'h08, 32'hFF);
    highs = 0;
    for (int i = 0; i < 1100; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      if (i > 0 && leds_o != 8'hFF) highs++;
    end
    chk("dutyff_never_off", highs, 0);

`ifdef LED_PWM_BLINK_EN
    // Blink: bits 1:0 toggle every two frames, bits 3:2 steady
    cyc(1'b0, 1'b0, 1'b1, 32'h00, 32'h0F);
    cyc(1'b0, 1'b0, 1'b1, 32'h0C, 32'h03);
    cyc(1'b0, 1'b0, 1'b1, 32'h10, 32'h2);
    toggles = 0;
    prev = 8'h0F;
    for (int i = 0; i < 4 * 2 * FRAME; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      if (leds_o[3:2] != 2'b11) highs++;
      if (leds_o != prev) toggles++;
      prev = leds_o;
    end
    chk("blink_toggles", toggles, 4);
    cyc(1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
`else
    // Blink offsets absent
    cyc(1'b0, 1'b0, 1'b1, 32'h0C, 32'h03);
    cyc(1'b0, 1'b0, 1'b1, 32'h10, 32'h02);
    cyc(1'b0, 1'b1, 1'b0, 32'h0C, 32'h0);
    chk("mask_absent", data_o, 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
    chk("half_absent", data_o, 32'h0);
    toggles = 0;
    prev = 8'h00;
`endif

    // Undecoded offset and idle read strobe
    cyc(1'b0, 1'b0, 1'b1, 32'h00, 32'h5A);
    cyc(1'b0, 1'b1, 1'b0, 32'h14, 32'h0);
    chk("rd_undecoded", data_o, 32'h0);
    cyc(1'b0, 1'b0, 1'b1, 32'h14, 32'hFFFF_FFFF);
    cyc(1'b0, 1'b1, 1'b0, 32'h04, 32'h0);
    chk("wr_undecoded_ctrl", data_o, 32'h5A);
    cyc(1'b0, 1'b0, 1'b0, 32'h04, 32'h0);
    chk("rd_en_low", data_o, 32'h0);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      int sel;
      logic [31:0] a, d;
      sel = $urandom_range(0, 15);
      a = {$urandom_range(0, 7), 2'b00};
      if ($urandom_range(0, 3) == 0) a[31:5] = $urandom;
      d = $urandom;
      if (sel == 0)      cyc(1'b0, $urandom_range(0, 1), 1'b1, 32'h00, d);
      else if (sel == 1) cyc(1'b0, $urandom_range(0, 1), 1'b1, 32'h08,
                             (d[1:0] == 0) ? 32'h0 : (d[1:0] == 1) ? 32'hFF : d);
      else if (sel == 2) cyc(1'b0, $urandom_range(0, 1), 1'b1, a, d & 32'h0000_FF03);
      else               cyc(1'b0, $urandom_range(0, 1), 1'b0, a, d);
    end

    // Reset mid-run clears everything
    cyc(1'b0, 1'b0, 1'b1, 32'h00, 32'hFF);
    cyc(1'b0, 1'b0, 1'b1, 32'h08, 32'h80);
    idle(300);
    cyc(1'b1, 1'b0, 1'b1, 32'h00, 32'h33);
    chk("rst_leds", {24'h0, leds_o}, 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 32'h04, 32'h0);
    chk("rst_ctrl_after", data_o, 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 32'h08, 32'h0);
    chk("rst_duty_after", data_o, 32'hFF);
    cyc(1'b0, 1'b1, 1'b0, 32'h0C, 32'h0);
    chk("rst_mask_after", data_o, 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
    chk("rst_half_after", data_o, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/led_pwm_peripheral.md
LED_PWM_PERIPHERAL -- requirements
Module: led_pwm_peripheral

Interface
REQ-001 Parameter NUM_LEDS, default 8: number of LED channels, legal range 1..32.
REQ-002 Parameter PWM_BITS, default 8: PWM counter and duty width, legal range 2..16.
REQ-003 Parameter PRESCALE, default 16: clk cycles per PWM count step, legal values >=1.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-006 rd_en_i  input  1  bus read strobe.
REQ-007 wr_en_i  input  1  bus write strobe.
REQ-008 addr_i  input  32  byte address; only addr_i[4:0] decoded.
REQ-009 data_i  input  32  write data.
REQ-010 data_o  output  32  read data; combinational.
REQ-011 leds_o  output  NUM_LEDS  LED drive; registered.

Function
REQ-012 Register map by offset: 0x00 CTRL write-only; 0x04 CTRL read-only (legacy map); 0x08 DUTY RW; 0x0C BLINK_MASK RW; 0x10 BLINK_HALF RW.
REQ-013 CTRL and BLINK_MASK are NUM_LEDS bits, DUTY is PWM_BITS bits, BLINK_HALF is 16 bits; each is written from the low bits of data_i, upper bits ignored.
REQ-014 Writes to undecoded offsets are ignored; reads of undecoded offsets, and any cycle with rd_en_i=0, return 0.
REQ-015 Read data is zero-extended to 32 bits.
REQ-016 Simultaneous read and write to the same offset returns the pre-write value; the new value is visible from the next cycle.
REQ-017 Prescaler counts 0..PRESCALE-1 and wraps; it asserts a one-cycle tick on the cycle its value equals PRESCALE-1.
REQ-018 PWM counter is PWM_BITS wide and increments on tick; on wrap from all-ones to 0 it asserts a one-cycle frame_end.
REQ-019 pwm_on: DUTY=0 -> always 0; DUTY=all-ones -> always 1; otherwise 1 when pwm_cnt < DUTY.
REQ-020 Blink counter is 16 bits and counts frame_end pulses; when a frame_end arrives while it equals BLINK_HALF-1, phase toggles and the counter clears.
REQ-021 When BLINK_HALF=0, phase is forced to 1 and the counter is held at 0.
REQ-022 A write to BLINK_HALF clears the blink counter and sets phase=1 in the same cycle the register loads.
REQ-023 leds_o[i] is registered as CTRL[i] & pwm_on & (~BLINK_MASK[i] | phase), giving one-cycle latency from any input change.
REQ-024 Prescaler and PWM counter run freely; register writes never reset them.

Reset
REQ-025 While rst=1, set CTRL=0, DUTY=all-ones, BLINK_MASK=0, BLINK_HALF=0, all counters=0, phase=1, leds_o=0.
REQ-026 Reset mid-frame or mid-blink aborts immediately; there is no partial-state retention.
REQ-027 rst has priority over a write in the same cycle.

Configuration
REQ-028 Macro LED_PWM_BLINK_EN: when defined, BLINK_MASK, BLINK_HALF, the blink counter and phase exist as specified above.
REQ-029 Without LED_PWM_BLINK_EN: offsets 0x0C and 0x10 read 0 and ignore writes, phase is constant 1, and no blink logic is synthesised.

Structure
REQ-030 Shared package led_pkg holds the register offset constants (0x00, 0x04, 0x08, 0x0C, 0x10) and the BLINK_HALF width constant (16).
REQ-031 Sub-module led_pwm_timebase holds the prescaler and PWM counter, parameterised by PRESCALE and PWM_BITS, and outputs pwm_cnt, tick and frame_end.
REQ-032 Register file, decode and output logic stay in the top module.

Verification (NUM_LEDS=8, PWM_BITS=8, PRESCALE=4)
REQ-033 Reset then write 0x00=0xA5 -> leds_o=0xA5 constant from cycle 2 after write; read 0x04 = 0x000000A5.
REQ-034 CTRL=0xFF, DUTY=0x40 -> each LED high for 64 of 256 PWM steps (256 of 1024 clk per frame).
REQ-035 DUTY=0x00 -> leds_o=0 always; DUTY=0xFF -> leds_o=0xFF always.
REQ-036 CTRL=0x0F, BLINK_MASK=0x03, BLINK_HALF=2 -> bits 1:0 toggle every 2 frames (2048 clk); bits 3:2 steady on.
REQ-037 Read 0x14 -> 0; write 0x14 -> no register changes; read of 0x04 with rd_en_i=0 -> 0.
REQ-038 Assert rst mid-blink -> next cycle leds_o=0 and all registers at reset values; without LED_PWM_BLINK_EN, 0x0C/0x10 read 0 after writes.
